// File: rtl/pipeline_ctrl_unit_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl_unit_pkg
//   Shared definitions for the pipeline sequencing controller:
//   - state encodings (IDLE/RUN/DRAIN/HALTED)
//   - stage index constants for the enable/flush vectors
//   - drain watchdog limit helper
// ----------------------------------------------------------------------------
package pipeline_ctrl_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } ctrl_state_e;

    // Bit positions inside stage_en_o / stage_flush_o.
    localparam int IDX_PC   = 0;
    localparam int IDX_IFID = 1;
    localparam int IDX_IDEX = 2;

    // Watchdog value at which a drain that has not seen halt_wb is abandoned.
    // The watchdog starts at 0 in the first DRAIN cycle, so this gives
    // n_stages + slack DRAIN cycles before the forced exit.
    function automatic int wd_limit(input int n_stages, input int slack);
        return n_stages + slack - 1;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_unit_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Up-counter with synchronous clear and saturation at all-ones.
//   Ports:
//     clock    in   rising-edge clock
//     reset    in   synchronous active-low reset (count -> 0)
//     clear_i  in   synchronous clear, wins over increment
//     inc_i    in   increment request
//     count_o  out  current count
//     sat_o    out  count is at its maximum value
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o,
    output logic             sat_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign sat_o   = &count_q;
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !sat_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl_unit
//   Central sequencing controller for the pipelined core. Produces the
//   per-register load enables and clear-to-NOP flushes for PC and every
//   inter-stage register, and handles free-run, single-step, load-use stall,
//   taken-branch flush and the halt drain.
//   Ports:
//     clock           in   rising-edge clock
//     reset           in   synchronous active-low reset
//     run_i           in   level, free-run requested
//     step_i          in   pulse, advance one cycle while IDLE
//     halt_decode_i   in   halt opcode in decode
//     halt_wb_i       in   halt has reached the last pipeline register
//     stall_i         in   load-use hazard
//     branch_taken_i  in   branch/jump resolved taken in decode
//     stage_en_o      out  per-register load enable (bit 0 = PC)
//     stage_flush_o   out  per-register clear, meaningful with its enable
//     state_o         out  current state
//     halted_o        out  controller is HALTED
//     drain_err_o     out  sticky, drain watchdog expired
//     cycle_cnt_o     out  saturating count of cycles the last register loaded
// ----------------------------------------------------------------------------
module pipeline_ctrl_unit
    import pipeline_ctrl_unit_pkg::*;
#(
    parameter int N_STAGES    = 5,
    parameter int DRAIN_SLACK = 2,
    parameter int NB_CNT      = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run_i,
    input  logic                step_i,
    input  logic                halt_decode_i,
    input  logic                halt_wb_i,
    input  logic                stall_i,
    input  logic                branch_taken_i,
    output logic [N_STAGES-1:0] stage_en_o,
    output logic [N_STAGES-1:0] stage_flush_o,
    output logic [1:0]          state_o,
    output logic                halted_o,
    output logic                drain_err_o,
    output logic [NB_CNT-1:0]   cycle_cnt_o
);

    localparam int WD_LIMIT = wd_limit(N_STAGES, DRAIN_SLACK);
    localparam int WD_W     = $clog2(WD_LIMIT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT_V = WD_W'(WD_LIMIT);

    // PC and IF/ID held, everything downstream keeps moving. Used both for
    // a load-use stall and for draining after a halt.
    localparam logic [N_STAGES-1:0] EN_HOLD_FRONT = {{(N_STAGES-2){1'b1}}, 2'b00};
    localparam logic [N_STAGES-1:0] EN_ALL        = '1;

    ctrl_state_e         state_q;
    ctrl_state_e         state_d;
    logic                drain_err_q;
    logic                drain_err_d;
    logic                advance;
    logic [N_STAGES-1:0] en_d;
    logic [N_STAGES-1:0] flush_d;

    logic [WD_W-1:0]     wd_count;
    logic                wd_sat;
    logic                wd_expire;
    logic                cnt_sat;

    assign wd_expire = (wd_count == WD_LIMIT_V) || wd_sat;

    always_comb begin
        state_d     = state_q;
        drain_err_d = drain_err_q;
        advance     = 1'b0;
        en_d        = '0;
        flush_d     = '0;

        unique case (state_q)
            ST_IDLE: begin
                advance = step_i;
                if (run_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A halt in decode is still honoured in the cycle run drops.
                if (run_i || halt_decode_i) begin
                    advance = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                en_d = EN_HOLD_FRONT;
                // halt_wb wins a tie with the watchdog, so no error is flagged.
                if (halt_wb_i) begin
                    state_d = ST_HALTED;
                end else if (wd_expire) begin
                    state_d     = ST_HALTED;
                    drain_err_d = 1'b1;
                end
            end
            ST_HALTED: begin
                en_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (advance) begin
            if (halt_decode_i) begin
                en_d              = EN_ALL;
                en_d[IDX_PC]      = 1'b0;
                flush_d[IDX_IFID] = 1'b1;
                state_d           = ST_DRAIN;
            end else if (stall_i) begin
                // A taken branch is dropped here; the hazard logic will
                // present it again once the stall clears.
                en_d              = EN_HOLD_FRONT;
                flush_d[IDX_IDEX] = 1'b1;
            end else if (branch_taken_i) begin
                en_d              = EN_ALL;
                flush_d[IDX_IFID] = 1'b1;
            end else begin
                en_d = EN_ALL;
            end
        end

        // Keep the pipeline frozen while reset is held.
        if (!reset) begin
            en_d    = '0;
            flush_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            drain_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_err_q <= drain_err_d;
        end
    end

    // Watchdog sits at 0 on DRAIN entry and counts each DRAIN cycle.
    sat_counter #(
        .WIDTH (WD_W)
    ) u_drain_wd (
        .clock   (clock),
        .reset   (reset),
        .clear_i (state_q != ST_DRAIN),
        .inc_i   (state_q == ST_DRAIN),
        .count_o (wd_count),
        .sat_o   (wd_sat)
    );

    sat_counter #(
        .WIDTH (NB_CNT)
    ) u_cycle_cnt (
        .clock   (clock),
        .reset   (reset),
        .clear_i (1'b0),
        .inc_i   (en_d[N_STAGES-1] && !cnt_sat),
        .count_o (cycle_cnt_o),
        .sat_o   (cnt_sat)
    );

    assign stage_en_o    = en_d;
    assign stage_flush_o = flush_d;
    assign state_o       = state_q;
    assign halted_o      = (state_q == ST_HALTED);
    assign drain_err_o   = drain_err_q;

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// ----------------------------------------------------------------------------
// tb_pipeline_ctrl_unit
//   Directed bench for pipeline_ctrl_unit. Three instances share stimulus:
//   the default configuration, a 3-bit cycle counter and a 6-stage pipeline.
//   Inputs change 1 time unit after the rising edge; combinational outputs
//   are sampled 2 time units later, registered outputs right after the edge.
// ----------------------------------------------------------------------------
module tb_pipeline_ctrl_unit;

    logic clock;
    logic reset;
    logic run_i;
    logic step_i;
    logic halt_decode_i;
    logic halt_wb_i;
    logic stall_i;
    logic branch_taken_i;

    logic [4:0]  stage_en_o;
    logic [4:0]  stage_flush_o;
    logic [1:0]  state_o;
    logic        halted_o;
    logic        drain_err_o;
    logic [31:0] cycle_cnt_o;

    logic [4:0]  s_en;
    logic [4:0]  s_flush;
    logic [1:0]  s_state;
    logic        s_halted;
    logic        s_err;
    logic [2:0]  s_cnt;

    logic [5:0]  w_en;
    logic [5:0]  w_flush;
    logic [1:0]  w_state;
    logic        w_halted;
    logic        w_err;
    logic [31:0] w_cnt;

    int checks;
    int errors;

    pipeline_ctrl_unit dut (
        .clock          (clock),
        .reset          (reset),
        .run_i          (run_i),
        .step_i         (step_i),
        .halt_decode_i  (halt_decode_i),
        .halt_wb_i      (halt_wb_i),
        .stall_i        (stall_i),
        .branch_taken_i (branch_taken_i),
        .stage_en_o     (stage_en_o),
        .stage_flush_o  (stage_flush_o),
        .state_o        (state_o),
        .halted_o       (halted_o),
        .drain_err_o    (drain_err_o),
        .cycle_cnt_o    (cycle_cnt_o)
    );

    pipeline_ctrl_unit #(.NB_CNT(3)) dut_sat (
        .clock          (clock),
        .reset          (reset),
        .run_i          (run_i),
        .step_i         (step_i),
        .halt_decode_i  (halt_decode_i),
        .halt_wb_i      (halt_wb_i),
        .stall_i        (stall_i),
        .branch_taken_i (branch_taken_i),
        .stage_en_o     (s_en),
        .stage_flush_o  (s_flush),
        .state_o        (s_state),
        .halted_o       (s_halted),
        .drain_err_o    (s_err),
        .cycle_cnt_o    (s_cnt)
    );

    pipeline_ctrl_unit #(.N_STAGES(6)) dut6 (
        .clock          (clock),
        .reset          (reset),
        .run_i          (run_i),
        .step_i         (step_i),
        .halt_decode_i  (halt_decode_i),
        .halt_wb_i      (halt_wb_i),
        .stall_i        (stall_i),
        .branch_taken_i (branch_taken_i),
        .stage_en_o     (w_en),
        .stage_flush_o  (w_flush),
        .state_o        (w_state),
        .halted_o       (w_halted),
        .drain_err_o    (w_err),
        .cycle_cnt_o    (w_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        run_i          = 1'b0;
        step_i         = 1'b0;
        halt_decode_i  = 1'b0;
        halt_wb_i      = 1'b0;
        stall_i        = 1'b0;
        branch_taken_i = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        checks++;
        if (stage_en_o !== 5'b0) begin
            errors++;
            $display("FAIL reset_en got %b want %b", stage_en_o, 5'b0);
        end
        checks++;
        if (stage_flush_o !== 5'b0) begin
            errors++;
            $display("FAIL reset_flush got %b want %b", stage_flush_o, 5'b0);
        end
        checks++;
        if (state_o !== 2'd0 || halted_o !== 1'b0 || drain_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got st=%0d h=%b e=%b want st=0 h=0 e=0",
                     state_o, halted_o, drain_err_o);
        end
        checks++;
        if (cycle_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d want 0", cycle_cnt_o);
        end
        $display("test_reset done");
        tick();
    endtask

    task automatic test_run();
        do_reset();
        run_i = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            #2;
            checks++;
            if (stage_en_o !== ((c == 1) ? 5'b00000 : 5'b11111)) begin
                errors++;
                $display("FAIL run_en cycle %0d got %b want %b", c, stage_en_o,
                         (c == 1) ? 5'b00000 : 5'b11111);
            end
            tick();
        end
        run_i = 1'b0;
        #2;
        checks++;
        if (stage_en_o !== 5'b0) begin
            errors++;
            $display("FAIL run_drop_en got %b want 00000", stage_en_o);
        end
        tick();
        checks++;
        if (cycle_cnt_o !== 32'd9 || state_o !== 2'd0) begin
            errors++;
            $display("FAIL run_cnt got cnt=%0d st=%0d want cnt=9 st=0",
                     cycle_cnt_o, state_o);
        end
        checks++;
        if (s_cnt !== 3'd7) begin
            errors++;
            $display("FAIL sat_cnt got %0d want 7", s_cnt);
        end
        do_reset();
        #1;
        checks++;
        if (cycle_cnt_o !== 32'd0 || stage_en_o !== 5'b0 || state_o !== 2'd0) begin
            errors++;
            $display("FAIL rerun_reset got cnt=%0d en=%b st=%0d want 0 0 0",
                     cycle_cnt_o, stage_en_o, state_o);
        end
        $display("test_run done cnt=9 sat=7 expected");
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        run_i = 1'b1;
        tick();
        tick();
        stall_i = 1'b1;
        #2;
        checks++;
        if (stage_en_o !== 5'b11100 || stage_flush_o !== 5'b00100) begin
            errors++;
            $display("FAIL stall got en=%b fl=%b want en=11100 fl=00100",
                     stage_en_o, stage_flush_o);
        end
        checks++;
        if (w_en !== 6'b111100 || w_flush !== 6'b000100) begin
            errors++;
            $display("FAIL stall6 got en=%b fl=%b want en=111100 fl=000100",
                     w_en, w_flush);
        end
        tick();
        stall_i = 1'b0;
        #2;
        checks++;
        if (stage_en_o !== 5'b11111 || stage_flush_o !== 5'b00000) begin
            errors++;
            $display("FAIL post_stall got en=%b fl=%b want en=11111 fl=00000",
                     stage_en_o, stage_flush_o);
        end
        tick();
        stall_i        = 1'b1;
        branch_taken_i = 1'b1;
        #2;
        checks++;
        if (stage_en_o !== 5'b11100 || stage_flush_o !== 5'b00100) begin
            errors++;
            $display("FAIL stall_branch got en=%b fl=%b want en=11100 fl=00100",
                     stage_en_o, stage_flush_o);
        end
        tick();
        stall_i = 1'b0;
        #2;
        checks++;
        if (stage_en_o !== 5'b11111 || stage_flush_o !== 5'b00010) begin
            errors++;
            $display("FAIL branch got en=%b fl=%b want en=11111 fl=00010",
                     stage_en_o, stage_flush_o);
        end
        tick();
        // Reset taken in the middle of a stall.
        branch_taken_i = 1'b0;
        stall_i        = 1'b1;
        reset          = 1'b0;
        tick();
        reset = 1'b1;
        #2;
        checks++;
        if (stage_en_o !== 5'b0 || stage_flush_o !== 5'b0 || state_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_stall got en=%b fl=%b st=%0d want 0 0 0",
                     stage_en_o, stage_flush_o, state_o);
        end
        $display("test_stall done");
        tick();
    endtask

    task automatic test_step();
        int adv;
        adv = 0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step_i = 1'b1;
            #2;
            if (stage_en_o === 5'b11111) adv++;
            tick();
            step_i = 1'b0;
            for (int g = 0; g < 3; g++) begin
                #2;
                if (stage_en_o === 5'b11111) adv++;
                checks++;
                if (state_o !== 2'd0) begin
                    errors++;
                    $display("FAIL step_state got %0d want 0", state_o);
                end
                tick();
            end
        end
        checks++;
        if (adv != 3) begin
            errors++;
            $display("FAIL step_adv got %0d want 3", adv);
        end
        checks++;
        if (cycle_cnt_o !== 32'd3) begin
            errors++;
            $display("FAIL step_cnt got %0d want 3", cycle_cnt_o);
        end
        $display("test_step done adv=%0d", adv);
    endtask

    task automatic test_halt();
        do_reset();
        run_i = 1'b1;
        tick();
        tick();
        halt_decode_i = 1'b1;
        #2;
        checks++;
        if (stage_en_o !== 5'b11110 || stage_flush_o !== 5'b00010) begin
            errors++;
            $display("FAIL halt_dec got en=%b fl=%b want en=11110 fl=00010",
                     stage_en_o, stage_flush_o);
        end
        tick();
        halt_decode_i = 1'b0;
        for (int d = 0; d < 3; d++) begin
            if (d == 2) halt_wb_i = 1'b1;
            #2;
            checks++;
            if (state_o !== 2'd2 || stage_en_o !== 5'b11100 || stage_flush_o !== 5'b0) begin
                errors++;
                $display("FAIL drain cycle %0d got st=%0d en=%b fl=%b want st=2 en=11100 fl=00000",
                         d, state_o, stage_en_o, stage_flush_o);
            end
            tick();
        end
        halt_wb_i = 1'b0;
        run_i     = 1'b0;
        #2;
        checks++;
        if (halted_o !== 1'b1 || stage_en_o !== 5'b0 || drain_err_o !== 1'b0 || state_o !== 2'd3) begin
            errors++;
            $display("FAIL halted got h=%b en=%b e=%b st=%0d want h=1 en=0 e=0 st=3",
                     halted_o, stage_en_o, drain_err_o, state_o);
        end
        $display("test_halt done");
        tick();
    endtask

    task automatic test_watchdog(input bool_tie);
        int ndrain;
        ndrain = 0;
        do_reset();
        run_i = 1'b1;
        tick();
        halt_decode_i = 1'b1;
        tick();
        halt_decode_i = 1'b0;
        run_i         = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (state_o !== 2'd2) break;
            ndrain++;
            if (bool_tie && ndrain == 7) halt_wb_i = 1'b1;
            tick();
        end
        halt_wb_i = 1'b0;
        checks++;
        if (ndrain != 7) begin
            errors++;
            $display("FAIL wd_cycles tie=%0d got %0d want 7", bool_tie, ndrain);
        end
        checks++;
        if (halted_o !== 1'b1 || drain_err_o !== !bool_tie) begin
            errors++;
            $display("FAIL wd_exit tie=%0d got h=%b e=%b want h=1 e=%b",
                     bool_tie, halted_o, drain_err_o, !bool_tie);
        end
        do_reset();
        #1;
        checks++;
        if (drain_err_o !== 1'b0 || halted_o !== 1'b0) begin
            errors++;
            $display("FAIL wd_reset got e=%b h=%b want 0 0", drain_err_o, halted_o);
        end
        $display("test_watchdog tie=%0d done drain=%0d", bool_tie, ndrain);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_run();
        test_stall();
        test_step();
        test_halt();
        test_watchdog(1'b0);
        test_watchdog(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl_unit.md
Name: pipeline_ctrl_unit

Overview:
Centralised pipeline sequencing controller for the MIPS core, replacing the single global en_pipeline and the ad-hoc stall/halt gating.
- Generates a per-register enable vector and flush vector for an N-stage pipeline: PC, then each inter-stage register.
- Sequences free-run, single-step, load-use stall, branch flush and halt drain.
- Counts retired cycles for the debug unit.
- Sits between the debug/UART controller and the pipeline registers.

Parameters:
N_STAGES, 5, number of pipeline registers controlled; bit 0 = PC, bit 1 = IF/ID, bit 2 = ID/EX, ..., bit N_STAGES-1 = last register (MEM/WB); minimum 3.
DRAIN_SLACK, 2, extra cycles allowed beyond N_STAGES for halt to reach writeback before watchdog trips.
NB_CNT, 32, width of the retired-cycle counter.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-low reset.
run_i  in  1  level; 1 = free-run mode requested.
step_i  in  1  one-cycle pulse; advance pipeline exactly one cycle while IDLE.
halt_decode_i  in  1  halt opcode present in decode.
halt_wb_i  in  1  halt has reached the last pipeline register output.
stall_i  in  1  load-use hazard detected (from hazard_unit).
branch_taken_i  in  1  branch/jump resolved taken in decode.
stage_en_o  out  N_STAGES  per-register load enable.
stage_flush_o  out  N_STAGES  per-register synchronous clear-to-NOP, valid only with matching enable bit.
state_o  out  2  current state encoding.
halted_o  out  1  1 in HALTED.
drain_err_o  out  1  sticky; watchdog expired during DRAIN.
cycle_cnt_o  out  NB_CNT  retired cycles, saturating.

Behaviour:
- Single clock domain; reset sampled on the rising edge when low.
- Reset state: IDLE. All outputs 0: stage_en_o, stage_flush_o, halted_o, drain_err_o, cycle_cnt_o; state_o = IDLE.
- State, watchdog and counter are registered. stage_en_o and stage_flush_o are combinational from registered state plus current inputs, giving zero-latency stall response.
- States: IDLE=0, RUN=1, DRAIN=2, HALTED=3.
- Advance cycle: state==RUN, or state==IDLE and step_i==1. Outside advance cycles and DRAIN, stage_en_o = 0.
- Advance cycle, priority high to low:
  - halt_decode_i: en all 1 except en[0]=0 (PC frozen); flush[1]=1 (IF/ID cleared); next state = DRAIN; stall_i and branch_taken_i ignored.
  - stall_i: en[0]=en[1]=0; en[N-1:2]=1; flush[2]=1 (bubble into ID/EX); branch_taken_i ignored this cycle, and hazard logic re-presents it next cycle.
  - branch_taken_i: en all 1; flush[1]=1.
  - otherwise: en all 1, flush 0.
- IDLE transitions: run_i=1 → RUN, taking effect the next cycle. A step_i pulse with no halt stays in IDLE. run_i and step_i together: step executes this cycle, then RUN.
- RUN transitions: run_i=0 and no halt → IDLE. The cycle run_i drops is not an advance cycle. halt_decode_i has priority over run_i drop.
- DRAIN:
  - en[1:0]=0; en[N-1:2]=1; flush 0; free-runs regardless of run_i/step_i.
  - Watchdog counter cleared on entry and incremented each DRAIN cycle.
  - halt_wb_i=1 → HALTED; enables remain as DRAIN for that cycle.
  - Watchdog reaching N_STAGES+DRAIN_SLACK-1 without halt_wb_i → HALTED with drain_err_o set.
  - Simultaneous halt_wb_i and watchdog expiry: HALTED, drain_err_o not set.
- HALTED: all en 0; halted_o=1; exits only by reset.
- cycle_cnt_o increments on each cycle where stage_en_o[N_STAGES-1]=1 and saturates at 2^NB_CNT-1, with no wrap.
- Reset mid-DRAIN or mid-stall: next cycle is IDLE with all outputs 0. Sticky flags are cleared.

Decomposition:
- Shared header pipeline_ctrl_defs: state encodings, stage index localparams (IDX_PC=0, IDX_IFID=1, IDX_IDEX=2), and the watchdog limit expression.
- Sub-module sat_counter (parametrised width, clear, increment, saturate flag), instantiated for cycle_cnt_o and the drain watchdog.

Test Plan:
- Reset, then run_i=1 for 10 cycles → stage_en_o=5'b11111 from cycle 2; cycle_cnt_o=9 after run_i drops. Reset again → all outputs 0.
- RUN with stall_i pulsed 1 cycle → that cycle stage_en_o=5'b11100 and stage_flush_o=5'b00100. With branch_taken_i also high in the same cycle → flush stays 5'b00100.
- IDLE with three step_i pulses spaced 4 cycles apart → exactly three cycles with stage_en_o=5'b11111; cycle_cnt_o=3; state_o stays 0.
- RUN, halt_decode_i=1 → that cycle en=5'b11110, flush=5'b00010; next cycles DRAIN with en=5'b11100. halt_wb_i three cycles later → halted_o=1, en=0, drain_err_o=0.
- DRAIN with halt_wb_i never asserted → HALTED after exactly 7 DRAIN cycles with drain_err_o=1. Reset → drain_err_o=0.
- NB_CNT=3, run 10 cycles → cycle_cnt_o saturates at 7. Re-elaborate with N_STAGES=6 and repeat the stall test → en=6'b111100, flush=6'b000100.
